// File: rtl/bcd_conv_pkg.sv
// Shared constants for the BCD-converter arbiter: data widths, digit limit and FSM encoding.
package bcd_conv_pkg;

  localparam int unsigned BcdW = 12;
  localparam int unsigned BinW = 10;
  localparam logic [3:0] DigitMax = 4'd9;

  typedef logic [1:0] state_t;

  localparam state_t StIdle  = 2'd0;
  localparam state_t StIssue = 2'd1;
  localparam state_t StWait  = 2'd2;
  localparam state_t StResp  = 2'd3;

  // True when any of the three nibbles is not a decimal digit.
  function automatic logic bcd_invalid(input logic [BcdW-1:0] v);
    return (v[3:0] > DigitMax) || (v[7:4] > DigitMax) || (v[11:8] > DigitMax);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set req bit searching upward from last_grant+1.
module rr_pick #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IdxW = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IdxW-1:0] last_grant,
  output logic [IdxW-1:0] grant,
  output logic            any
);

  always_comb begin
    int unsigned idx;
    idx   = 0;
    grant = '0;
    any   = 1'b0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = (32'(last_grant) + k) % NREQ;
      if (!any && req[idx]) begin
        grant = idx[IdxW-1:0];
        any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bcd_conv_arbiter.sv
// Shares one BCD-to-binary converter among NREQ requesters with round-robin grant,
// operand validation and a converter timeout.
module bcd_conv_arbiter
  import bcd_conv_pkg::*;
#(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned TIMEOUT = 31
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [BcdW*NREQ-1:0] req_bcd,
  output logic [NREQ-1:0]      ack,
  output logic [BinW-1:0]      rsp_bin,
  output logic                 rsp_err,
  output logic                 busy,
  output logic                 conv_start,
  output logic [BcdW-1:0]      conv_bcd,
  input  logic [BinW-1:0]      conv_bin,
  input  logic                 conv_done
);

  localparam int unsigned IdxW = $clog2(NREQ);
  localparam int unsigned TmrW = 8;
  localparam logic [TmrW-1:0] TmrLast = TmrW'(TIMEOUT - 1);

  state_t          state_q, state_d;
  logic [IdxW-1:0] grant_q, grant_d;
  logic [IdxW-1:0] last_q, last_d;
  logic [BcdW-1:0] bcd_q, bcd_d;
  logic [BinW-1:0] bin_q, bin_d;
  logic            err_q, err_d;
  logic [TmrW-1:0] timer_q, timer_d;

  logic [IdxW-1:0] pick;
  logic            pick_any;

  rr_pick #(
    .NREQ(NREQ),
    .IdxW(IdxW)
  ) u_rr_pick (
    .req       (req),
    .last_grant(last_q),
    .grant     (pick),
    .any       (pick_any)
  );

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    bcd_d   = bcd_q;
    bin_d   = bin_q;
    err_d   = err_q;
    timer_d = timer_q;
    case (state_q)
      StIdle: begin
        if (pick_any) begin
          grant_d = pick;
          bcd_d   = req_bcd[32'(pick)*BcdW +: BcdW];
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (bcd_invalid(bcd_q)) begin
          bin_d   = '0;
          err_d   = 1'b1;
          state_d = StResp;
        end else begin
          timer_d = '0;
          state_d = StWait;
        end
      end
      StWait: begin
        // A completion in the timeout cycle still wins.
        if (conv_done) begin
          bin_d   = conv_bin;
          err_d   = 1'b0;
          state_d = StResp;
        end else if (timer_q == TmrLast) begin
          bin_d   = '0;
          err_d   = 1'b1;
          state_d = StResp;
        end else begin
          timer_d = timer_q + TmrW'(1);
        end
      end
      StResp: begin
        last_d  = grant_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      grant_q <= '0;
      last_q  <= IdxW'(NREQ - 1);
      bcd_q   <= '0;
      bin_q   <= '0;
      err_q   <= 1'b0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      bcd_q   <= bcd_d;
      bin_q   <= bin_d;
      err_q   <= err_d;
      timer_q <= timer_d;
    end
  end

  logic in_resp;
  assign in_resp    = (state_q == StResp);
  assign busy       = (state_q != StIdle);
  assign conv_start = (state_q == StIssue) && !bcd_invalid(bcd_q);
  assign conv_bcd   = bcd_q;
  assign ack        = in_resp ? (NREQ'(1) << grant_q) : '0;
  assign rsp_bin    = in_resp ? bin_q : '0;
  assign rsp_err    = in_resp & err_q;

endmodule

// File: doc/bcd_conv_arbiter.md
BCD_CONV_ARBITER -- requirements
Module: bcd_conv_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing one BCD-to-binary converter (2..8).
REQ-002 Parameter TIMEOUT, default 31: maximum cycles spent waiting for conv_done (4..255).
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 req  in  NREQ  per-requester request level; held until that requester's ack.
REQ-006 req_bcd  in  12*NREQ  packed 3-digit BCD operand; requester i occupies bits [12i+11:12i], held with req.
REQ-007 ack  out  NREQ  one-cycle pulse on the granted requester's bit when rsp_bin/rsp_err are valid.
REQ-008 rsp_bin  out  10  binary result, valid only while any ack bit is high.
REQ-009 rsp_err  out  1  error flag (invalid BCD digit or converter timeout), valid with ack.
REQ-010 busy  out  1  high in every state except IDLE.
REQ-011 conv_start  out  1  one-cycle start pulse to the converter.
REQ-012 conv_bcd  out  12  operand to the converter; stable from the conv_start cycle until RESP.
REQ-013 conv_bin  in  10  converter result, sampled only in the conv_done cycle.
REQ-014 conv_done  in  1  converter completion pulse.

Function
REQ-015 FSM states SHALL be IDLE, ISSUE, WAIT and RESP; one operation in flight at a time.
REQ-016 IDLE: if any req bit is high, the block SHALL grant round-robin, searching from (last_grant+1) mod NREQ upward, latch the grant index and its req_bcd, and go to ISSUE.
REQ-017 ISSUE: if any latched digit exceeds 9, the block SHALL go to RESP with err=1, bin=0 and no conv_start; otherwise it SHALL assert conv_start for exactly this cycle, clear the wait timer and go to WAIT.
REQ-018 WAIT: on conv_done=1 the block SHALL capture conv_bin with err=0 and go to RESP.
REQ-019 WAIT: the timer SHALL increment each cycle; if it equals TIMEOUT-1 and conv_done=0, the block SHALL go to RESP with err=1, bin=0.
REQ-020 If conv_done and the timeout condition occur in the same cycle, conv_done SHALL take priority.
REQ-021 conv_done outside WAIT SHALL be ignored.
REQ-022 RESP: ack[grant] SHALL be 1 for exactly one cycle with rsp_bin/rsp_err driven; last_grant SHALL update to the grant index; next state is IDLE.
REQ-023 rsp_bin and rsp_err SHALL be 0 in all cycles where ack is 0.
REQ-024 A requester dropping req after grant SHALL NOT abort the operation; its ack is still issued.
REQ-025 A req still high in the IDLE cycle after its ack SHALL be treated as a new request.
REQ-026 Latency: req seen in IDLE at cycle t gives conv_start at t+1; conv_done at cycle d gives ack at d+1; an invalid operand gives ack at t+2.
REQ-027 Changes to req or req_bcd while busy=1 SHALL have no effect on the current operation.

Reset
REQ-028 While rst_n=0: state=IDLE, ack=0, rsp_bin=0, rsp_err=0, busy=0, conv_start=0, conv_bcd=0, timer=0, last_grant=NREQ-1, so requester 0 has priority first.
REQ-029 Reset asserted mid-operation SHALL discard the operation with no ack; a later conv_done SHALL be ignored.

Structure
REQ-030 Package bcd_conv_pkg SHALL hold the FSM state encoding, the BCD width (12), the binary width (10) and the digit-limit constant 9.
REQ-031 Round-robin selection SHALL be one combinational sub-module, rr_pick: inputs req and last_grant; outputs the grant index and an any-request flag.

Verification
REQ-032 req=0001, req_bcd[11:0]=0x255, model returns done 11 cycles after start with 0x0FF -> conv_bcd=0x255, ack=0001 one cycle, rsp_bin=255, rsp_err=0.
REQ-033 req=1111 held until each ack, all operands valid -> acks in order 0,1,2,3, then 0 again, with exactly one conv_start per grant.
REQ-034 req=0100, operand 0x1A3 -> no conv_start, ack=0100 at t+2, rsp_err=1, rsp_bin=0.
REQ-035 Model never asserts conv_done, TIMEOUT=31 -> ack exactly 31 cycles after the first WAIT cycle, rsp_err=1; a late conv_done is ignored.
REQ-036 Operand 0x999 -> rsp_bin=999 (0x3E7); conv_done and the timeout in the same cycle -> rsp_err=0 with the captured value.
REQ-037 rst_n pulsed low during WAIT -> all outputs 0 immediately; the next req=0010 grants requester 1 only if req[0]=0.
